// File: rtl/cell_particle_mem.sv
`default_nettype none
// ============================================================================
// Module   : cell_particle_mem
// Purpose  : Double-buffered particle store for one cell, with bank swap and
//            sweep-clearing of the retired bank.
// Revision : 1.0 - initial release
// ============================================================================
module cell_particle_mem #(
    parameter int DBSIZE = 256,
    parameter int CW     = $clog2(DBSIZE) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [32:0]   iaddr,
    input  logic          we,
    input  logic [96:0]   po,
    input  logic [96:0]   vo,
    input  logic          swap,
    output logic [96:0]   pi,
    output logic [96:0]   vi,
    output logic [1:0]    double_buffer,
    output logic          ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic          err_oob
);

    localparam int         DEPTH   = 2 * DBSIZE;
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [96:0] NULL_W = {1'b1, 96'b0};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [95:0]      pos_mem [DEPTH];
    logic [95:0]      vel_mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic          rd_bank0;
    logic          clr_bank;
    logic [CW-1:0] clr_cnt;

    logic          in_range;
    logic [AW-1:0] idx;
    logic          idx_bank1;
    logic          acc;
    logic          wr;
    logic          rd;
    logic          oob;
    logic          swap_go;
    logic          last_clr;
    logic [AW-1:0] clr_idx;

    assign in_range  = (iaddr[31:0] < 32'(DEPTH));
    assign idx       = iaddr[AW-1:0];
    assign idx_bank1 = (idx >= AW'(DBSIZE));
    assign acc       = (state == ST_IDLE) && ready && !iaddr[32];
    assign wr        = acc && in_range && we;
    assign rd        = acc && in_range && !we;
    assign oob       = acc && !in_range;
    assign swap_go   = (state == ST_IDLE) && swap;
    assign last_clr  = (state == ST_CLEAR) && (clr_cnt == CW'(DBSIZE - 1));
    assign clr_idx   = clr_bank ? (AW'(DBSIZE) + AW'(clr_cnt)) : AW'(clr_cnt);

    assign double_buffer = {(state == ST_CLEAR), rd_bank0};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  state_nxt = ST_IDLE;
            ST_IDLE:  if (swap_go) state_nxt = ST_CLEAR;
            ST_CLEAR: if (last_clr) state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // ready lags the return to IDLE by one cycle so the updater never sees
    // it high on the same edge the sweep finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            ready    <= 1'b0;
            rd_bank0 <= 1'b1;
            clr_bank <= 1'b0;
            clr_cnt  <= '0;
        end else begin
            state <= state_nxt;
            ready <= (state == ST_IDLE) && (state_nxt == ST_IDLE);
            if (swap_go) begin
                rd_bank0 <= !rd_bank0;
                clr_bank <= !rd_bank0;
                clr_cnt  <= '0;
            end else if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            cnt0  <= '0;
            cnt1  <= '0;
        end else begin
            if (wr) begin
                valid[idx] <= !po[96];
                if (!po[96] && !valid[idx]) begin
                    if (idx_bank1) cnt1 <= cnt1 + CW'(1);
                    else           cnt0 <= cnt0 + CW'(1);
                end else if (po[96] && valid[idx]) begin
                    if (idx_bank1) cnt1 <= cnt1 - CW'(1);
                    else           cnt0 <= cnt0 - CW'(1);
                end
            end
            if (state == ST_CLEAR) begin
                valid[clr_idx] <= 1'b0;
                if (last_clr) begin
                    if (clr_bank) cnt1 <= '0;
                    else          cnt0 <= '0;
                end else if (valid[clr_idx]) begin
                    if (clr_bank) cnt1 <= cnt1 - CW'(1);
                    else          cnt0 <= cnt0 - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !po[96]) begin
            pos_mem[idx] <= po[95:0];
            vel_mem[idx] <= vo[95:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi      <= NULL_W;
            vi      <= NULL_W;
            err_oob <= 1'b0;
        end else begin
            err_oob <= oob;
            if (rd && valid[idx]) begin
                pi <= {1'b0, pos_mem[idx]};
                vi <= {1'b0, vel_mem[idx]};
            end else begin
                pi <= NULL_W;
                vi <= NULL_W;
            end
        end
    end

endmodule
`default_nettype wire
